// File: rtl/peripheral_mpram_arbiter_ahb4.sv
// rtl/peripheral_mpram_arbiter_ahb4.sv - N AHB4 slave ports sharing one single-port RAM
// Each port holds its master in a wait state until the round-robin arbiter hands it the RAM for one cycle.
module peripheral_mpram_arbiter_ahb4 #(
    parameter int CORES_PER_TILE = 8,
    parameter int PLEN           = 64,
    parameter int XLEN           = 64,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                                      HCLK,
    input  logic                                      HRESET,
    input  logic [CORES_PER_TILE-1:0]                 HSEL,
    input  logic [CORES_PER_TILE-1:0][PLEN-1:0]       HADDR,
    input  logic [CORES_PER_TILE-1:0][XLEN-1:0]       HWDATA,
    input  logic [CORES_PER_TILE-1:0]                 HWRITE,
    input  logic [CORES_PER_TILE-1:0][2:0]            HSIZE,
    input  logic [CORES_PER_TILE-1:0][1:0]            HTRANS,
    input  logic [CORES_PER_TILE-1:0]                 HREADY,
    output logic [CORES_PER_TILE-1:0]                 HREADYOUT,
    output logic [CORES_PER_TILE-1:0]                 HRESP,
    output logic [CORES_PER_TILE-1:0][XLEN-1:0]       HRDATA,
    output logic                                      mem_req,
    output logic                                      mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]              mem_addr,
    output logic [XLEN/8-1:0]                         mem_be,
    output logic [XLEN-1:0]                           mem_wdata,
    input  logic [XLEN-1:0]                           mem_rdata
);

    localparam int BW  = XLEN / 8;
    localparam int OFS = $clog2(BW);
    localparam int MW  = $clog2(MEM_DEPTH);
    localparam int AW  = OFS + MW;
    localparam int PW  = (CORES_PER_TILE > 1) ? $clog2(CORES_PER_TILE) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;

    state_t           state_q [CORES_PER_TILE];
    state_t           state_d [CORES_PER_TILE];
    logic [AW-1:0]    addr_q  [CORES_PER_TILE];
    logic             write_q [CORES_PER_TILE];
    logic [2:0]       size_q  [CORES_PER_TILE];

    logic [CORES_PER_TILE-1:0] capture;
    logic [CORES_PER_TILE-1:0] grant;
    logic [PW-1:0]             rr_q;
    logic [PW-1:0]             winner;
    logic [PW-1:0]             idx;
    logic                      found;
    logic                      unused_bits;
    int                        be_lo;
    int                        be_n;

    // Only the word and byte-lane bits of HADDR reach the RAM; HTRANS[0] only splits IDLE/BUSY and NONSEQ/SEQ.
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < CORES_PER_TILE; i++) begin
            unused_bits = unused_bits ^ (^HADDR[i][PLEN-1:AW]) ^ HTRANS[i][0];
        end
    end

    always_comb begin
        for (int i = 0; i < CORES_PER_TILE; i++) begin
            capture[i]   = HSEL[i] & HREADY[i] & HTRANS[i][1] &
                           ((state_q[i] == ST_IDLE) | (state_q[i] == ST_DONE) | (state_q[i] == ST_ERR2));
            state_d[i]   = state_q[i];
            HREADYOUT[i] = !((state_q[i] == ST_WAIT) || (state_q[i] == ST_ERR1));
            HRESP[i]     = (state_q[i] == ST_ERR1) || (state_q[i] == ST_ERR2);
            HRDATA[i]    = ((state_q[i] == ST_DONE) && !write_q[i]) ? mem_rdata : '0;
            case (state_q[i])
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (capture[i]) state_d[i] = (HSIZE[i] > 3'(OFS)) ? ST_ERR1 : ST_WAIT;
                    else            state_d[i] = ST_IDLE;
                end
                ST_WAIT: if (grant[i]) state_d[i] = ST_DONE;
                ST_ERR1: state_d[i] = ST_ERR2;
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Round-robin search begins just past the last winner so every waiting port is served within N cycles.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        idx    = '0;
        grant  = '0;
        for (int k = 1; k <= CORES_PER_TILE; k++) begin
            idx = PW'((int'(rr_q) + k) % CORES_PER_TILE);
            if (!found && (state_q[idx] == ST_WAIT)) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found) grant[winner] = 1'b1;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        be_lo     = 0;
        be_n      = 0;
        if (found) begin
            mem_req   = 1'b1;
            mem_we    = write_q[winner];
            mem_addr  = addr_q[winner][AW-1:OFS];
            mem_wdata = HWDATA[winner];
            be_lo     = int'(addr_q[winner][OFS-1:0]);
            be_n      = 1 << size_q[winner];
            // Lanes past the top of the word simply fall off, so misaligned accesses truncate.
            for (int b = 0; b < BW; b++) begin
                mem_be[b] = (b >= be_lo) && (b < be_lo + be_n);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rr_q <= PW'(CORES_PER_TILE - 1);
            for (int i = 0; i < CORES_PER_TILE; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                write_q[i] <= 1'b0;
                size_q[i]  <= '0;
            end
        end else begin
            if (found) rr_q <= winner;
            for (int i = 0; i < CORES_PER_TILE; i++) begin
                state_q[i] <= state_d[i];
                if (capture[i]) begin
                    addr_q[i]  <= HADDR[i][AW-1:0];
                    write_q[i] <= HWRITE[i];
                    size_q[i]  <= HSIZE[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_peripheral_mpram_arbiter_ahb4.sv
// tb/tb_peripheral_mpram_arbiter_ahb4.sv - self-checking bench for the shared-RAM AHB4 arbiter
module tb_peripheral_mpram_arbiter_ahb4;

    localparam int N = 8;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [N-1:0]      HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [N-1:0][63:0] HADDR, HWDATA, HRDATA;
    logic [N-1:0][2:0] HSIZE;
    logic [N-1:0][1:0] HTRANS;
    logic              mem_req, mem_we;
    logic [7:0]        mem_addr, mem_be;
    logic [63:0]       mem_wdata, mem_rdata;

    logic [63:0] ram     [256];
    logic [63:0] ref_mem [256];
    int total = 0;
    int bad   = 0;
    int rr_m  = N - 1;

    peripheral_mpram_arbiter_ahb4 #(
        .CORES_PER_TILE(N), .PLEN(64), .XLEN(64), .MEM_DEPTH(256)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++) if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic samp;
        @(negedge HCLK);
    endtask

    task automatic clear_bus;
        HSEL   = '0;
        HTRANS = '0;
        HWRITE = '0;
        HSIZE  = '0;
    endtask

    task automatic set_port(input logic [2:0] p, input logic wr, input logic [63:0] a,
                            input logic [2:0] sz, input logic [63:0] wd);
        HSEL[p]   = 1'b1;
        HTRANS[p] = 2'b10;
        HWRITE[p] = wr;
        HADDR[p]  = a;
        HSIZE[p]  = sz;
        HWDATA[p] = wd;
    endtask

    function automatic logic [7:0] exp_be(input logic [63:0] a, input logic [2:0] sz);
        int m;
        m = ((1 << (1 << sz)) - 1) << a[2:0];
        return m[7:0];
    endfunction

    task automatic ref_write(input logic [7:0] w, input logic [7:0] be, input logic [63:0] d);
        for (int b = 0; b < 8; b++) if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic test_reset;
        HRESET = 1'b1;
        clear_bus();
        HADDR = '0;
        HWDATA = '0;
        repeat (2) samp();
        total++; if (HREADYOUT !== 8'hFF) begin bad++; $display("FAIL rst_hreadyout got=%h exp=ff", HREADYOUT); end
        total++; if (HRESP !== 8'h00) begin bad++; $display("FAIL rst_hresp got=%h exp=00", HRESP); end
        total++; if (HRDATA !== '0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
        total++; if ({mem_req, mem_we, mem_be} !== 10'd0) begin bad++; $display("FAIL rst_mem got=%b/%b/%h exp=0/0/00", mem_req, mem_we, mem_be); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rr_m = N - 1;
        samp();
        total++; if ({HREADYOUT, mem_req} !== 9'h1FE) begin bad++; $display("FAIL post_rst got=%h/%b exp=ff/0", HREADYOUT, mem_req); end
        tick();
    endtask

    task automatic test_all_ports;
        for (int p = 0; p < N; p++) set_port(3'(p), 1'b0, 64'(p * 8), 3'd3, 64'd0);
        tick();
        clear_bus();
        for (int j = 0; j < N; j++) begin
            samp();
            total++; if (!mem_req || mem_we !== 1'b0 || mem_addr !== 8'(j)) begin bad++; $display("FAIL all_grant%0d got=%b/%0d exp=1/%0d", j, mem_req, mem_addr, j); end
            total++; if (HREADYOUT !== 8'((1 << j) - 1)) begin bad++; $display("FAIL all_wait%0d got=%h exp=%h", j, HREADYOUT, 8'((1 << j) - 1)); end
            if (j > 0) begin
                total++; if (HRDATA[3'(j-1)] !== ref_mem[j-1]) begin bad++; $display("FAIL all_rdata%0d got=%h exp=%h", j-1, HRDATA[3'(j-1)], ref_mem[j-1]); end
            end
            tick();
        end
        samp();
        total++; if (HRDATA[7] !== ref_mem[7]) begin bad++; $display("FAIL all_rdata7 got=%h exp=%h", HRDATA[7], ref_mem[7]); end
        total++; if (HREADYOUT !== 8'hFF || mem_req !== 1'b0) begin bad++; $display("FAIL all_end got=%h/%b exp=ff/0", HREADYOUT, mem_req); end
        rr_m = N - 1;
        tick();
    endtask

    task automatic test_single_write;
        set_port(3'd0, 1'b1, 64'h10, 3'd3, 64'hDEADBEEF_CAFEF00D);
        tick();
        clear_bus();
        samp();
        total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL w_req got=%b%b exp=11", mem_req, mem_we); end
        total++; if (mem_addr !== 8'd2 || mem_be !== 8'hFF) begin bad++; $display("FAIL w_addr_be got=%0d/%h exp=2/ff", mem_addr, mem_be); end
        total++; if (mem_wdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL w_wdata got=%h exp=deadbeefcafef00d", mem_wdata); end
        total++; if (HREADYOUT[0] !== 1'b0) begin bad++; $display("FAIL w_stall got=%b exp=0", HREADYOUT[0]); end
        tick();
        samp();
        total++; if (HREADYOUT[0] !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL w_done got=%b/%b exp=1/0", HREADYOUT[0], mem_req); end
        ref_write(8'd2, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        rr_m = 0;
        tick();
    endtask

    task automatic test_single_read;
        set_port(3'd3, 1'b0, 64'h10, 3'd3, 64'd0);
        tick();
        clear_bus();
        samp();
        total++; if ({mem_req, mem_we, HREADYOUT[3]} !== 3'b100 || mem_addr !== 8'd2) begin bad++; $display("FAIL r_grant got=%b%b%b/%0d exp=100/2", mem_req, mem_we, HREADYOUT[3], mem_addr); end
        tick();
        samp();
        total++; if (HREADYOUT[3] !== 1'b1 || HRESP[3] !== 1'b0) begin bad++; $display("FAIL r_done got=%b/%b exp=1/0", HREADYOUT[3], HRESP[3]); end
        total++; if (HRDATA[3] !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL r_data got=%h exp=deadbeefcafef00d", HRDATA[3]); end
        rr_m = 3;
        tick();
    endtask

    task automatic test_byte_and_error;
        set_port(3'd2, 1'b1, 64'h13, 3'd0, 64'hAB << 24);
        tick();
        clear_bus();
        samp();
        total++; if ({mem_req, mem_we} !== 2'b11 || mem_be !== 8'h08 || mem_addr !== 8'd2) begin bad++; $display("FAIL byte_w got=%b%b/%h/%0d exp=11/08/2", mem_req, mem_we, mem_be, mem_addr); end
        tick();
        ref_write(8'd2, 8'h08, 64'hAB << 24);
        rr_m = 2;
        set_port(3'd2, 1'b0, 64'h20, 3'd4, 64'd0);
        tick();
        clear_bus();
        samp();
        total++; if ({HREADYOUT[2], HRESP[2], mem_req} !== 3'b010) begin bad++; $display("FAIL err1 got=%b%b%b exp=010", HREADYOUT[2], HRESP[2], mem_req); end
        tick();
        samp();
        total++; if ({HREADYOUT[2], HRESP[2], mem_req} !== 3'b110) begin bad++; $display("FAIL err2 got=%b%b%b exp=110", HREADYOUT[2], HRESP[2], mem_req); end
        tick();
        samp();
        total++; if ({HREADYOUT[2], HRESP[2]} !== 2'b10) begin bad++; $display("FAIL err_idle got=%b%b exp=10", HREADYOUT[2], HRESP[2]); end
        tick();
    endtask

    task automatic test_back_to_back;
        int first, other, exp_p, run1, run5, max_run;
        first = -1;
        for (int k = 1; k <= N; k++) begin
            if (first < 0 && (((rr_m + k) % N) == 1 || ((rr_m + k) % N) == 5)) first = (rr_m + k) % N;
        end
        other = (first == 1) ? 5 : 1;
        run1 = 0; run5 = 0; max_run = 0;
        set_port(3'd1, 1'b0, 64'd8, 3'd3, 64'd0);
        set_port(3'd5, 1'b0, 64'd40, 3'd3, 64'd0);
        tick();
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) clear_bus();
            samp();
            exp_p = (c % 2 == 0) ? first : other;
            total++; if (mem_req !== 1'b1 || mem_addr !== 8'(exp_p)) begin bad++; $display("FAIL b2b_grant%0d got=%b/%0d exp=1/%0d", c, mem_req, mem_addr, exp_p); end
            run1 = HREADYOUT[1] ? 0 : run1 + 1;
            run5 = HREADYOUT[5] ? 0 : run5 + 1;
            if (run1 > max_run) max_run = run1;
            if (run5 > max_run) max_run = run5;
            tick();
        end
        samp();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", mem_req); end
        total++; if (max_run > 2) begin bad++; $display("FAIL b2b_maxwait got=%0d exp<=2", max_run); end
        rr_m = first;
        tick();
    endtask

    task automatic test_random(input int rounds);
        logic [7:0]  mask, exp_ro;
        logic [2:0]  order[$];
        logic [2:0]  p, q;
        logic        wr_a [N];
        logic [2:0]  sz_a [N];
        logic [63:0] ad_a [N];
        logic [63:0] wd_a [N];
        logic [63:0] rd_a [N];
        for (int r = 0; r < rounds; r++) begin
            mask = 8'($urandom_range(1, 255));
            clear_bus();
            for (int i = 0; i < N; i++) begin
                if (mask[3'(i)]) begin
                    wr_a[i] = 1'($urandom);
                    sz_a[i] = 3'($urandom_range(0, 3));
                    ad_a[i] = {$urandom(), $urandom()} & ~((64'd1 << sz_a[i]) - 64'd1);
                    wd_a[i] = {$urandom(), $urandom()};
                    set_port(3'(i), wr_a[i], ad_a[i], sz_a[i], wd_a[i]);
                end
            end
            order.delete();
            for (int k = 1; k <= N; k++) if (mask[3'((rr_m + k) % N)]) order.push_back(3'((rr_m + k) % N));
            tick();
            clear_bus();
            for (int j = 0; j < order.size(); j++) begin
                samp();
                p = order[j];
                exp_ro = 8'hFF;
                for (int m = j; m < order.size(); m++) exp_ro[order[m]] = 1'b0;
                total++; if (mem_req !== 1'b1 || mem_we !== wr_a[p] || mem_addr !== ad_a[p][10:3]) begin bad++; $display("FAIL rnd%0d_grant got=%b%b/%0d exp=1%b/%0d", r, mem_req, mem_we, mem_addr, wr_a[p], ad_a[p][10:3]); end
                total++; if (mem_be !== exp_be(ad_a[p], sz_a[p])) begin bad++; $display("FAIL rnd%0d_be got=%h exp=%h", r, mem_be, exp_be(ad_a[p], sz_a[p])); end
                if (wr_a[p]) begin
                    total++; if (mem_wdata !== wd_a[p]) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", r, mem_wdata, wd_a[p]); end
                end
                total++; if (HREADYOUT !== exp_ro) begin bad++; $display("FAIL rnd%0d_ready got=%h exp=%h", r, HREADYOUT, exp_ro); end
                if (j > 0) begin
                    q = order[j-1];
                    total++; if (HRDATA[q] !== (wr_a[q] ? 64'd0 : rd_a[q])) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", r, HRDATA[q], wr_a[q] ? 64'd0 : rd_a[q]); end
                end
                if (wr_a[p]) ref_write(ad_a[p][10:3], exp_be(ad_a[p], sz_a[p]), wd_a[p]);
                else rd_a[p] = ref_mem[ad_a[p][10:3]];
                tick();
            end
            samp();
            q = order[order.size()-1];
            total++; if (HRDATA[q] !== (wr_a[q] ? 64'd0 : rd_a[q])) begin bad++; $display("FAIL rnd%0d_lastdata got=%h exp=%h", r, HRDATA[q], wr_a[q] ? 64'd0 : rd_a[q]); end
            total++; if (HREADYOUT !== 8'hFF || HRESP !== 8'h00 || mem_req !== 1'b0) begin bad++; $display("FAIL rnd%0d_end got=%h/%h/%b exp=ff/00/0", r, HREADYOUT, HRESP, mem_req); end
            rr_m = int'(q);
            tick();
        end
    endtask

    task automatic test_reset_midflight;
        for (int p = 0; p < 4; p++) set_port(3'(p), 1'b1, 64'((200 + p) * 8), 3'd3, {$urandom(), $urandom()});
        tick();
        clear_bus();
        #1;
        HRESET = 1'b1;
        #1;
        total++; if (HREADYOUT !== 8'hFF || mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL midrst got=%h/%b/%b exp=ff/0/0", HREADYOUT, mem_req, mem_we); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rr_m = N - 1;
        for (int p = 0; p < 4; p++) set_port(3'(p), 1'b0, 64'((200 + p) * 8), 3'd3, 64'd0);
        tick();
        clear_bus();
        for (int j = 0; j < 4; j++) begin
            samp();
            total++; if (mem_req !== 1'b1 || mem_addr !== 8'(200 + j)) begin bad++; $display("FAIL midrst_grant%0d got=%b/%0d exp=1/%0d", j, mem_req, mem_addr, 200 + j); end
            if (j > 0) begin
                total++; if (HRDATA[3'(j-1)] !== ref_mem[200+j-1]) begin bad++; $display("FAIL midrst_nowrite%0d got=%h exp=%h", j-1, HRDATA[3'(j-1)], ref_mem[200+j-1]); end
            end
            tick();
        end
        samp();
        total++; if (HRDATA[3] !== ref_mem[203]) begin bad++; $display("FAIL midrst_nowrite3 got=%h exp=%h", HRDATA[3], ref_mem[203]); end
        rr_m = 3;
        tick();
    endtask

    initial begin
        HRESET = 1'b1;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = {$urandom(), $urandom()};
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_all_ports();
        test_single_write();
        test_single_read();
        test_byte_and_error();
        test_back_to_back();
        test_random(40);
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
